// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter slice.
//   LINE_W_DEF  : default memory line width in bits
//   LADDR_W_DEF : default line address width (byte address [31:4])
//   arb_state_t : arbiter FSM states
//   src_t       : identifies which requester owns the current transaction
package mem_pkg;

    localparam int LINE_W_DEF  = 128;
    localparam int LADDR_W_DEF = 28;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a registered last-grant pointer.
// Ports:
//   clk, reset_n     : clock, asynchronous active-low reset
//   req_i, req_d     : instruction / data side requests
//   take             : the grant is being consumed this cycle; updates the pointer
//   grant_i, grant_d : combinational one-hot (or zero) grant
module rr_arb2
    import mem_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_i,
    input  logic req_d,
    input  logic take,
    output logic grant_i,
    output logic grant_d
);

    src_t last_gnt;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (req_i && req_d) begin
            if (last_gnt == SRC_I) begin
                grant_d = 1'b1;
            end else begin
                grant_i = 1'b1;
            end
        end else begin
            grant_i = req_i;
            grant_d = req_d;
        end
    end

    // Pointer starts at I so the first tie after reset is won by D.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt <= SRC_I;
        end else if (take && (grant_i || grant_d)) begin
            last_gnt <= grant_d ? SRC_D : SRC_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an I-cache read port and a D-cache read/write-back port onto a
// single-outstanding memory interface.
// Ports:
//   clk, reset_n                      : clock, asynchronous active-low reset
//   reqI, reqAddrI, flushI            : I-side request, line address, discard pending response
//   dataI, readyI                     : I-side returned line, read-done pulse
//   reqD, weD, reqAddrD, wdataD       : D-side request, write enable, line address, write line
//   dataD, readyD, ackD               : D-side returned line, read-done pulse, write-done pulse
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ready   : memory request channel and completion pulse
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int LADDR_W = LADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               reqI,
    input  logic [LADDR_W-1:0] reqAddrI,
    input  logic               flushI,
    output logic [LINE_W-1:0]  dataI,
    output logic               readyI,
    input  logic               reqD,
    input  logic               weD,
    input  logic [LADDR_W-1:0] reqAddrD,
    input  logic [LINE_W-1:0]  wdataD,
    output logic [LINE_W-1:0]  dataD,
    output logic               readyD,
    output logic               ackD,
    output logic               mem_req,
    output logic               mem_we,
    output logic [LADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0]  mem_wdata,
    input  logic [LINE_W-1:0]  mem_rdata,
    input  logic               mem_ready
);

    arb_state_t state;
    arb_state_t state_next;
    src_t       cur_src;
    logic       drop_flag;
    logic       grant_i;
    logic       grant_d;
    logic       in_idle;

    assign in_idle = (state == IDLE);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset_n (reset_n),
        .req_i   (reqI),
        .req_d   (reqD),
        .take    (in_idle),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Memory has no timeout: a busy state waits as long as mem_ready stays low.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_next = BUSY_I;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory request fields are captured once when leaving IDLE and then held
    // untouched until completion, so the memory never sees them change mid-flight.
    // The drop flag only arms while an I read is outstanding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            dataI     <= '0;
            dataD     <= '0;
            cur_src   <= SRC_I;
            drop_flag <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    drop_flag <= 1'b0;
                    if (grant_i) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= reqAddrI;
                        mem_wdata <= '0;
                        cur_src   <= SRC_I;
                    end else if (grant_d) begin
                        mem_req   <= 1'b1;
                        mem_we    <= weD;
                        mem_addr  <= reqAddrD;
                        mem_wdata <= wdataD;
                        cur_src   <= SRC_D;
                    end
                end
                BUSY_I: begin
                    if (flushI) begin
                        drop_flag <= 1'b1;
                    end
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        dataI   <= mem_rdata;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        dataD   <= mem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Completion pulses are decoded from the RESP state; reset forces IDLE,
    // which keeps all three low without extra registers.
    always_comb begin
        readyI = (state == RESP) && (cur_src == SRC_I) && !drop_flag;
        readyD = (state == RESP) && (cur_src == SRC_D) && !mem_we;
        ackD   = (state == RESP) && (cur_src == SRC_D) && mem_we;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LINE_W, default 128, memory line width in bits.
REQ-002 SHALL have parameter LADDR_W, default 28, line address width (byte address [31:4]).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports reqI (in, 1, I-cache read request, level), reqAddrI (in, LADDR_W), flushI (in, 1, discard pending I response).
REQ-006 SHALL have ports dataI (out, LINE_W, returned line), readyI (out, 1, one-cycle read-done pulse).
REQ-007 SHALL have ports reqD (in, 1), weD (in, 1, 1=write-back), reqAddrD (in, LADDR_W), wdataD (in, LINE_W).
REQ-008 SHALL have ports dataD (out, LINE_W), readyD (out, 1, read-done pulse), ackD (out, 1, write-done pulse).
REQ-009 SHALL have memory ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, LADDR_W), mem_wdata (out, LINE_W), mem_rdata (in, LINE_W), mem_ready (in, 1, one-cycle completion pulse).

Function
REQ-010 SHALL implement states IDLE, BUSY_I, BUSY_D, RESP.
REQ-011 IDLE: reqI only -> BUSY_I; reqD only -> BUSY_D; both -> the requester not granted last (round-robin); neither -> stay.
REQ-012 last-grant register SHALL reset to I, so the first tie after reset goes to D.
REQ-013 On the edge leaving IDLE, mem_req, mem_we, mem_addr, mem_wdata SHALL be registered from the winner (mem_we=0 for I) and held constant until mem_ready.
REQ-014 BUSY_x: on edge with mem_ready=1, mem_req SHALL drop, mem_rdata SHALL latch into dataI/dataD, go to RESP; otherwise stay (no timeout).
REQ-015 In RESP exactly one of readyI, readyD, ackD SHALL be 1 for that single cycle; next state IDLE unconditionally.
REQ-016 Requests SHALL be ignored in RESP; requester drops req during its ready/ack cycle; a req still high in IDLE is a new request.
REQ-017 Minimum latency request-seen to ready pulse: 3 cycles with mem_ready on first mem_req cycle; one grant at most every 3 cycles.
REQ-018 flushI=1 in any cycle of BUSY_I SHALL set a drop flag; memory transaction completes normally but readyI SHALL stay 0 in RESP; flag clears in IDLE.
REQ-019 flushI in IDLE/RESP or during BUSY_D SHALL have no effect.
REQ-020 mem_ready in IDLE or RESP SHALL be ignored.
REQ-021 dataI/dataD SHALL hold last latched value until next completion for that port.
REQ-022 Addresses pass unmodified; no width conversion.

Reset
REQ-023 reset_n=0 SHALL immediately force state IDLE, last-grant I, drop flag 0, mem_req/mem_we/readyI/readyD/ackD 0, mem_addr/mem_wdata/dataI/dataD 0.
REQ-024 Reset mid-transaction SHALL abandon it; no ready/ack issued after release.

Structure
REQ-025 Package mem_pkg SHALL hold LINE_W, LADDR_W defaults and the state enum type.
REQ-026 Sub-module rr_arb2 (two-requester round-robin, registered last-grant) SHALL be used.

Verification
REQ-027 reqI, addr 0x0000010, mem_ready 2 cycles after mem_req -> mem_addr=0x0000010, mem_we=0, readyI 1 cycle, dataI=mem_rdata.
REQ-028 reqI and reqD (read, 0x0000020) together after reset -> D served first, I next; mem_req low one cycle minimum between.
REQ-029 Persistent reqI and reqD, 4 transactions -> grants alternate D,I,D,I.
REQ-030 reqD weD=1 addr 0x00000FF wdata 0xA5..A5 -> mem_we=1, mem_wdata=0xA5..A5, ackD pulse, readyD=0.
REQ-031 reqI then flushI in BUSY_I -> mem transaction completes, readyI never asserted, next reqI served normally.
REQ-032 reset_n low while BUSY_D -> mem_req 0 immediately, no ackD/readyD after release, IDLE.
